// File: rtl/bnn_pkg.sv
// bnn_pkg: shared definitions for the host-side BNN classifier blocks.
//   - sequencer state encoding
//   - bit positions inside the classifier's uo_out bus
//   - feature slot order on the ui_in/uio_in lines
//   - default vote batch size and capture timeout
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OUT     = 2'd3
  } state_e;

  // classifier uo_out layout: [2:0]=class, [3]=done, [7:4]=hidden_act
  localparam int CLS_LSB  = 0;
  localparam int DONE_BIT = 3;
  localparam int HID_LSB  = 4;

  // feature slots, in the order nibbles arrive
  localparam int SLOT_HEIGHT = 0;
  localparam int SLOT_COLOR  = 1;
  localparam int SLOT_WIDTH  = 2;
  localparam int SLOT_STEM   = 3;

  localparam int NUM_FEAT_DEF = 4;
  localparam int FEAT_W_DEF   = 4;
  localparam int VOTE_N_DEF   = 3;
  localparam int TIMEOUT_DEF  = 32;

endpackage

// File: rtl/bnn_done_edge.sv
// bnn_done_edge: registers the classifier done level every cycle and flags
// its rising edge. A done level held high is reported only once.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   done        raw done level from the classifier
//   done_rise   one-cycle pulse: done high now, low last cycle
module bnn_done_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic done,
  output logic done_rise
);

  logic done_prev_q;
  logic done_prev_d;

  always_comb begin
    done_prev_d = done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_prev_q <= 1'b0;
    end else begin
      done_prev_q <= done_prev_d;
    end
  end

  assign done_rise = done & ~done_prev_q;

endmodule

// File: rtl/bnn_feature_sequencer.sv
// bnn_feature_sequencer: packs four feature nibbles onto the classifier
// input lines, runs the classifier for one pass, captures its class and
// hidden activations, and majority-votes VOTE_N vectors into one result.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_valid/s_ready/s_feat          feature nibble stream in
//   clf_ui_in, clf_uio_in, clf_ena  classifier inputs
//   clf_uo_out                      classifier output bus
//   m_valid/m_ready                 batch result handshake
//   m_class, m_votes1, m_hidden,
//   m_timeout                       batch result fields
//   busy                            high outside COLLECT
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_COLLECT | accepting nibbles into slots 0..3
// ST_ARM     | classifier enabled; first done edge is dropped (stale pass)
// ST_CAPTURE | next done edge samples class and hidden activations
// ST_OUT     | batch result presented until m_ready
module bnn_feature_sequencer
  import bnn_pkg::*;
#(
  parameter int NUM_FEAT = NUM_FEAT_DEF,
  parameter int FEAT_W   = FEAT_W_DEF,
  parameter int VOTE_N   = VOTE_N_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_feat,
  output logic [7:0]        clf_ui_in,
  output logic [7:0]        clf_uio_in,
  output logic              clf_ena,
  input  logic [7:0]        clf_uo_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_class,
  output logic [3:0]        m_votes1,
  output logic [3:0]        m_hidden,
  output logic              m_timeout,
  output logic              busy
);

  localparam int IDX_W = $clog2(NUM_FEAT);
  localparam int TMR_W = $clog2(TIMEOUT);

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [NUM_FEAT-1:0][FEAT_W-1:0]  feat_q, feat_d;
  logic [TMR_W-1:0]                 tmr_q, tmr_d;
  logic [3:0]                       votes1_q, votes1_d;
  logic [3:0]                       vcount_q, vcount_d;
  logic [3:0]                       hidden_q, hidden_d;
  logic                             timeout_q, timeout_d;
  logic                             s_ready_q, s_ready_d;

  logic       done_rise;
  logic       accept;
  logic       expired;
  logic [3:0] vcount_inc;
  logic [5:0] votes_x2;
  logic       unused_cls;

  bnn_done_edge u_done_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .done      (clf_uo_out[DONE_BIT]),
    .done_rise (done_rise)
  );

  // only class bit 0 is voted on
  assign unused_cls = ^clf_uo_out[CLS_LSB+1 +: 2];

  assign accept     = s_valid & s_ready_q;
  assign expired    = (tmr_q == '0);
  assign vcount_inc = vcount_q + 4'd1;
  assign votes_x2   = {1'b0, votes1_q, 1'b0};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    feat_d    = feat_q;
    tmr_d     = tmr_q;
    votes1_d  = votes1_q;
    vcount_d  = vcount_q;
    hidden_d  = hidden_q;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          feat_d[idx_q] = s_feat;
          if (idx_q == IDX_W'(NUM_FEAT - 1)) begin
            idx_d   = '0;
            tmr_d   = TMR_W'(TIMEOUT - 1);
            state_d = ST_ARM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_ARM: begin
        // a discarded edge is not a capture, so it cannot rescue an expiry
        if (expired) begin
          timeout_d = 1'b1;
          state_d   = ST_OUT;
        end else begin
          tmr_d = tmr_q - 1'b1;
          if (done_rise) begin
            state_d = ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        if (!expired) begin
          tmr_d = tmr_q - 1'b1;
        end
        if (done_rise) begin
          votes1_d = votes1_q + {3'b000, clf_uo_out[CLS_LSB]};
          hidden_d = clf_uo_out[HID_LSB +: 4];
          vcount_d = vcount_inc;
          state_d  = (vcount_inc == 4'(VOTE_N)) ? ST_OUT : ST_COLLECT;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = ST_OUT;
        end
      end

      ST_OUT: begin
        if (m_ready) begin
          votes1_d  = '0;
          vcount_d  = '0;
          timeout_d = 1'b0;
          state_d   = ST_COLLECT;
        end
      end

      default: state_d = ST_COLLECT;
    endcase

    // registered so s_ready stays low while reset is asserted
    s_ready_d = (state_d == ST_COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_COLLECT;
      idx_q     <= '0;
      feat_q    <= '0;
      tmr_q     <= '0;
      votes1_q  <= '0;
      vcount_q  <= '0;
      hidden_q  <= '0;
      timeout_q <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      feat_q    <= feat_d;
      tmr_q     <= tmr_d;
      votes1_q  <= votes1_d;
      vcount_q  <= vcount_d;
      hidden_q  <= hidden_d;
      timeout_q <= timeout_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign clf_ui_in  = {feat_q[SLOT_COLOR], feat_q[SLOT_HEIGHT]};
  assign clf_uio_in = {feat_q[SLOT_STEM], feat_q[SLOT_WIDTH]};
  assign clf_ena    = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
  assign busy       = (state_q != ST_COLLECT);
  assign m_valid    = (state_q == ST_OUT);
  assign m_class    = m_valid && !timeout_q && (votes_x2 > 6'(VOTE_N));
  assign m_votes1   = votes1_q;
  assign m_hidden   = hidden_q;
  assign m_timeout  = timeout_q;

endmodule

// File: tb/tb_bnn_feature_sequencer.sv
module tb_bnn_feature_sequencer;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_feat;
  logic [7:0] clf_ui_in;
  logic [7:0] clf_uio_in;
  logic       clf_ena;
  logic [7:0] clf_uo_out;
  logic       m_valid;
  logic       m_ready;
  logic       m_class;
  logic [3:0] m_votes1;
  logic [3:0] m_hidden;
  logic       m_timeout;
  logic       busy;

  int total = 0;
  int bad   = 0;

  bnn_feature_sequencer #(
    .NUM_FEAT (4),
    .FEAT_W   (4),
    .VOTE_N   (3),
    .TIMEOUT  (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_feat     (s_feat),
    .clf_ui_in  (clf_ui_in),
    .clf_uio_in (clf_uio_in),
    .clf_ena    (clf_ena),
    .clf_uo_out (clf_uo_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_class    (m_class),
    .m_votes1   (m_votes1),
    .m_hidden   (m_hidden),
    .m_timeout  (m_timeout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"},   32'(s_ready),    0);
    chk({tag, "_ui"},        32'(clf_ui_in),  0);
    chk({tag, "_uio"},       32'(clf_uio_in), 0);
    chk({tag, "_ena"},       32'(clf_ena),    0);
    chk({tag, "_m_valid"},   32'(m_valid),    0);
    chk({tag, "_m_class"},   32'(m_class),    0);
    chk({tag, "_m_votes1"},  32'(m_votes1),   0);
    chk({tag, "_m_hidden"},  32'(m_hidden),   0);
    chk({tag, "_m_timeout"}, 32'(m_timeout),  0);
    chk({tag, "_busy"},      32'(busy),       0);
  endtask

  // presents one nibble; returns at the negedge after it was accepted
  task automatic send_nibble(input logic [3:0] n);
    int w = 0;
    while (!s_ready && w < 20) begin
      tick();
      w++;
    end
    if (!s_ready) chk("s_ready_wait", 32'(s_ready), 1);
    s_valid = 1'b1;
    s_feat  = n;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [3:0] n0, input logic [3:0] n1,
                          input logic [3:0] n2, input logic [3:0] n3);
    send_nibble(n0);
    send_nibble(n1);
    send_nibble(n2);
    send_nibble(n3);
  endtask

  // Cycle 0 is the first ARM cycle. Stub done pulses: class 1 / hidden F at
  // disc (dropped), then cls/hid at cap. Returns at the negedge of cap+1.
  task automatic run_vector(input logic [3:0] n0, input logic [3:0] n1,
                            input logic [3:0] n2, input logic [3:0] n3,
                            input logic [7:0] exp_ui, input logic [7:0] exp_uio,
                            input int disc, input int cap,
                            input logic cls, input logic [3:0] hid);
    send_vec(n0, n1, n2, n3);
    for (int k = 0; k <= cap; k++) begin
      if (k == disc)      clf_uo_out = 8'hF9;
      else if (k == cap)  clf_uo_out = {hid, 1'b1, 2'b00, cls};
      else                clf_uo_out = 8'h00;
      if (k == 0 || k == cap) begin
        chk("pack_ui",      32'(clf_ui_in),  32'(exp_ui));
        chk("pack_uio",     32'(clf_uio_in), 32'(exp_uio));
        chk("run_ena",      32'(clf_ena),    1);
        chk("run_s_ready",  32'(s_ready),    0);
      end
      tick();
    end
    clf_uo_out = 8'h00;
  endtask

  initial begin
    int k;
    rst_n      = 1'b0;
    s_valid    = 1'b0;
    s_feat     = 4'h0;
    clf_uo_out = 8'h00;
    m_ready    = 1'b0;

    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("post_reset_s_ready", 32'(s_ready), 1);
    chk("post_reset_busy",    32'(busy),    0);

    // vector 1: pack 9,2,12,3, class 1
    run_vector(4'd9, 4'd2, 4'd12, 4'd3, 8'h29, 8'h3C, 1, 6, 1'b1, 4'h3);
    chk("v1_busy",    32'(busy),     0);
    chk("v1_m_valid", 32'(m_valid),  0);
    chk("v1_s_ready", 32'(s_ready),  1);
    chk("v1_votes1",  32'(m_votes1), 1);

    // vector 2: dropped pulse says class 1, real capture says class 0
    run_vector(4'd4, 4'd5, 4'd6, 4'd7, 8'h54, 8'h76, 1, 6, 1'b0, 4'h6);
    chk("v2_discard_votes1", 32'(m_votes1), 1);
    chk("v2_busy",           32'(busy),     0);

    // vector 3: class 1 -> batch 1,0,1
    run_vector(4'd1, 4'd0, 4'd15, 4'd8, 8'h01, 8'h8F, 1, 3, 1'b1, 4'hA);
    chk("vote_m_valid",   32'(m_valid),   1);
    chk("vote_m_class",   32'(m_class),   1);
    chk("vote_m_votes1",  32'(m_votes1),  2);
    chk("vote_m_timeout", 32'(m_timeout), 0);
    chk("vote_m_hidden",  32'(m_hidden),  32'h A);
    chk("vote_ena",       32'(clf_ena),   0);
    chk("vote_busy",      32'(busy),      1);

    for (int i = 0; i < 7; i++) begin
      tick();
      chk("bp_m_valid", 32'(m_valid),  1);
      chk("bp_m_class", 32'(m_class),  1);
      chk("bp_votes1",  32'(m_votes1), 2);
      chk("bp_hidden",  32'(m_hidden), 32'hA);
      chk("bp_s_ready", 32'(s_ready),  0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("hs_m_valid", 32'(m_valid),  0);
    chk("hs_s_ready", 32'(s_ready),  1);
    chk("hs_votes1",  32'(m_votes1), 0);
    chk("hs_busy",    32'(busy),     0);

    // timeout: classifier never raises done
    send_vec(4'd1, 4'd2, 4'd3, 4'd4);
    k = 0;
    while (!m_valid && k < 40) begin
      tick();
      k++;
    end
    chk("to_cycles",    32'(k),         32);
    chk("to_m_timeout", 32'(m_timeout), 1);
    chk("to_m_class",   32'(m_class),   0);
    chk("to_m_votes1",  32'(m_votes1),  0);
    chk("to_ena",       32'(clf_ena),   0);
    chk("to_ui_hold",   32'(clf_ui_in), 32'h21);
    chk("to_uio_hold",  32'(clf_uio_in), 32'h43);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("to_clr_timeout", 32'(m_timeout), 0);
    chk("to_clr_m_valid", 32'(m_valid),   0);

    // capture on the very cycle the timer expires: capture wins
    run_vector(4'd3, 4'd3, 4'd3, 4'd3, 8'h33, 8'h33, 1, 31, 1'b1, 4'h5);
    chk("race_m_valid",   32'(m_valid),   0);
    chk("race_m_timeout", 32'(m_timeout), 0);
    chk("race_votes1",    32'(m_votes1),  1);
    chk("race_busy",      32'(busy),      0);

    // reset after two nibbles of the next vector
    send_nibble(4'hE);
    send_nibble(4'hD);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    tick();
    rst_n = 1'b1;

    run_vector(4'd5, 4'd6, 4'd7, 4'd8, 8'h65, 8'h87, 1, 6, 1'b1, 4'h2);
    chk("rst_v1_busy",   32'(busy),     0);
    chk("rst_v1_votes1", 32'(m_votes1), 1);
    run_vector(4'd0, 4'd1, 4'd2, 4'd3, 8'h10, 8'h32, 1, 6, 1'b0, 4'h4);
    chk("rst_v2_m_valid", 32'(m_valid), 0);
    chk("rst_v2_busy",    32'(busy),    0);
    run_vector(4'd8, 4'd8, 4'd1, 4'd1, 8'h88, 8'h11, 1, 6, 1'b1, 4'h7);
    chk("rst_v3_m_valid", 32'(m_valid),  1);
    chk("rst_v3_m_class", 32'(m_class),  1);
    chk("rst_v3_votes1",  32'(m_votes1), 2);
    chk("rst_v3_hidden",  32'(m_hidden), 32'h7);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("rst_v3_hs_s_ready", 32'(s_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
